// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundles the core write/read ports and the debug access
// port of regfile_mp.
//   wr_en_i/wr_add_i/wr_data_i : two core write ports, packed per port
//   r_add_i/r_data_o           : NRD core read ports, packed per port
//   dbg_*                      : single debug request/ack access port
//   stall_o                    : asks the core to hold writes next cycle
// master = core/debugger side, slave = register file.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
) ();
  logic [1:0]          wr_en_i;
  logic [2*AW-1:0]     wr_add_i;
  logic [2*XLEN-1:0]   wr_data_i;
  logic [NRD*AW-1:0]   r_add_i;
  logic [NRD*XLEN-1:0] r_data_o;
  logic                dbg_req_i;
  logic                dbg_we_i;
  logic [AW-1:0]       dbg_add_i;
  logic [XLEN-1:0]     dbg_wdata_i;
  logic [XLEN-1:0]     dbg_rdata_o;
  logic                dbg_ack_o;
  logic                stall_o;

  modport master (
    output wr_en_i, wr_add_i, wr_data_i, r_add_i,
    output dbg_req_i, dbg_we_i, dbg_add_i, dbg_wdata_i,
    input  r_data_o, dbg_rdata_o, dbg_ack_o, stall_o
  );

  modport slave (
    input  wr_en_i, wr_add_i, wr_data_i, r_add_i,
    input  dbg_req_i, dbg_we_i, dbg_add_i, dbg_wdata_i,
    output r_data_o, dbg_rdata_o, dbg_ack_o, stall_o
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hard-wired to zero, two core
// write ports (port 1 wins on collision), NRD bypassed combinational read
// ports, and a debug access port that slips into cycles without core writes,
// stalling the core after DBG_TIMEOUT busy cycles.
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : regfile_mp_if.slave (core write/read ports, debug port, stall)
//
// Debug FSM
//   state  | meaning
//   IDLE   | no debug request pending
//   WAIT   | request pending, core writing; counting busy cycles
//   STALL  | timeout reached; stall_o asks core to drop its writes
//   ACCESS | access done at entry edge; dbg_ack_o/dbg_rdata_o valid
module regfile_mp #(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int NRD         = 2,
  parameter int DBG_TIMEOUT = 15
) (
  input logic        clk,
  input logic        rst,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = (DBG_TIMEOUT < 1) ? 1 : $clog2(DBG_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, STALL, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              go_access;
  logic              bus_idle;
  logic [XLEN-1:0]   mem [NREGS];
  logic [AW-1:0]     wa0, wa1;
  logic [XLEN-1:0]   wd0, wd1;
  logic [NRD*XLEN-1:0] rd_all;

  assign wa0      = bus.wr_add_i[0 +: AW];
  assign wa1      = bus.wr_add_i[AW +: AW];
  assign wd0      = bus.wr_data_i[0 +: XLEN];
  assign wd1      = bus.wr_data_i[XLEN +: XLEN];
  assign bus_idle = (bus.wr_en_i == 2'b00);

  // go_access marks the edge that performs the debug access; it is only
  // raised in a cycle without core writes, so the two never collide.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go_access = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dbg_req_i) begin
          if (bus_idle) begin
            state_nxt = ACCESS;
            go_access = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = '0;
          end
        end
      end
      WAIT: begin
        if (!bus.dbg_req_i) begin
          state_nxt = IDLE;
        end else if (bus_idle) begin
          state_nxt = ACCESS;
          go_access = 1'b1;
        end else if (cnt == CW'(DBG_TIMEOUT)) begin
          state_nxt = STALL;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STALL: begin
        if (!bus.dbg_req_i) begin
          state_nxt = IDLE;
        end else if (bus_idle) begin
          state_nxt = ACCESS;
          go_access = 1'b1;
        end
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.dbg_ack_o   <= 1'b0;
      bus.dbg_rdata_o <= '0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      bus.dbg_ack_o   <= go_access;
      bus.dbg_rdata_o <= (go_access && !bus.dbg_we_i) ? mem[bus.dbg_add_i] : '0;
    end
  end

  assign bus.stall_o = (state == STALL);

  // Port 1 is written after port 0 so it wins on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      if (bus.wr_en_i[0] && wa0 != '0) mem[wa0] <= wd0;
      if (bus.wr_en_i[1] && wa1 != '0) mem[wa1] <= wd1;
      if (go_access && bus.dbg_we_i && bus.dbg_add_i != '0)
        mem[bus.dbg_add_i] <= bus.dbg_wdata_i;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;
    assign ra = bus.r_add_i[g*AW +: AW];
    always_comb begin
      val = mem[ra];
      if (bus.wr_en_i[0] && wa0 == ra) val = wd0;
      if (bus.wr_en_i[1] && wa1 == ra) val = wd1;
      if (ra == '0 || rst) val = '0;
    end
    assign rd_all[g*XLEN +: XLEN] = val;
  end

  assign bus.r_data_o = rd_all;
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREGS = 16;
  localparam int NRD = 4;
  localparam int AW = 4;
  localparam int TMO = 15;

  typedef struct {int p; logic [31:0] v;} rd_t;
  typedef struct {bit we; logic [AW-1:0] a; logic [31:0] d;} dbg_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus ();
  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .DBG_TIMEOUT(TMO))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int ack_cyc = 0;
  int stall_cyc = -1;
  bit stall_last = 0;
  logic [31:0] model [NREGS];
  rd_t  rd_q[$];
  dbg_t dbg_q[$];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: pops expected read data each cycle it was queued, and a debug
  // expectation whenever the DUT acknowledges.
  always @(negedge clk) begin
    while (rd_q.size() > 0) begin
      rd_t e;
      e = rd_q.pop_front();
      check($sformatf("r_data[%0d]", e.p), bus.r_data_o[e.p*XLEN +: XLEN], e.v);
    end
    if (bus.dbg_ack_o) begin
      ack_cnt++;
      ack_cyc = cyc;
      if (dbg_q.size() == 0) begin
        check("unexpected_ack", {31'b0, bus.dbg_ack_o}, 32'd0);
      end else begin
        dbg_t d;
        d = dbg_q.pop_front();
        if (!d.we) check("dbg_rdata", bus.dbg_rdata_o, d.d);
        else if (d.a != 0) model[d.a] = d.d;
      end
    end
    if (bus.stall_o && stall_cyc < 0) stall_cyc = cyc;
    stall_last = bus.stall_o;
  end

  // One core cycle: drive ports, queue expected reads, advance the model.
  task automatic core_cyc(input bit r, input logic [1:0] en,
                          input logic [AW-1:0] a0, input logic [31:0] d0,
                          input logic [AW-1:0] a1, input logic [31:0] d1,
                          input logic [NRD*AW-1:0] ra);
    @(posedge clk); #1;
    rst = r;
    bus.wr_en_i   = en;
    bus.wr_add_i  = {a1, a0};
    bus.wr_data_i = {d1, d0};
    bus.r_add_i   = ra;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] q;
      logic [31:0] v;
      q = ra[i*AW +: AW];
      v = model[q];
      if (en[0] && a0 == q) v = d0;
      if (en[1] && a1 == q) v = d1;
      if (q == 0 || r) v = 0;
      rd_q.push_back('{i, v});
    end
    if (r) begin
      for (int i = 0; i < NREGS; i++) model[i] = 0;
    end else begin
      if (en[0] && a0 != 0) model[a0] = d0;
      if (en[1] && a1 != 0) model[a1] = d1;
    end
  endtask

  function automatic logic [NRD*AW-1:0] rand_ra(bit avoid9);
    logic [NRD*AW-1:0] ra;
    for (int i = 0; i < NRD; i++) begin
      int unsigned q;
      q = $urandom_range(0, NREGS - 1);
      if (avoid9 && q == 9) q = 8;
      ra[i*AW +: AW] = q[AW-1:0];
    end
    return ra;
  endfunction

  task automatic idle_cyc();
    core_cyc(0, 2'b00, 0, 0, 0, 0, rand_ra(0));
  endtask

  task automatic dbg_go(input bit we, input logic [AW-1:0] a, input logic [31:0] d,
                        output int rc);
    int start;
    bit got;
    @(posedge clk); #1;
    bus.dbg_req_i   = 1;
    bus.dbg_we_i    = we;
    bus.dbg_add_i   = a;
    bus.dbg_wdata_i = d;
    rc = cyc;
    dbg_q.push_back('{we, a, we ? d : (a == 0 ? 32'd0 : model[a])});
    start = ack_cnt;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge clk); #1;
      if (ack_cnt != start) got = 1;
    end
    bus.dbg_req_i = 0;
    check("dbg_ack_seen", {31'b0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, a0c;
    logic [NRD*AW-1:0] ra;
    rst = 1;
    bus.wr_en_i = 0; bus.wr_add_i = 0; bus.wr_data_i = 0; bus.r_add_i = 0;
    bus.dbg_req_i = 0; bus.dbg_we_i = 0; bus.dbg_add_i = 0; bus.dbg_wdata_i = 0;
    for (int i = 0; i < NREGS; i++) model[i] = 0;

    // reset, with write attempts that must be ignored
    core_cyc(1, 2'b11, 3, 32'h1111, 4, 32'h2222, {4'd4, 4'd3, 4'd2, 4'd1});
    core_cyc(1, 2'b00, 0, 0, 0, 0, {4'd4, 4'd3, 4'd2, 4'd1});
    @(negedge clk);
    check("reset_ack", {31'b0, bus.dbg_ack_o}, 32'd0);
    check("reset_stall", {31'b0, bus.stall_o}, 32'd0);
    check("reset_dbg_rdata", bus.dbg_rdata_o, 32'd0);
    idle_cyc();

    // same-address write collision, bypass, then array content
    core_cyc(0, 2'b11, 5, 32'h1234, 5, 32'hABCD, {4'd7, 4'd0, 4'd5, 4'd5});
    core_cyc(0, 2'b00, 0, 0, 0, 0, {4'd5, 4'd5, 4'd5, 4'd5});
    core_cyc(0, 2'b01, 6, 32'h6666, 5, 32'h0, {4'd6, 4'd5, 4'd6, 4'd0});
    core_cyc(0, 2'b10, 6, 32'h0, 6, 32'h7777, {4'd6, 4'd5, 4'd6, 4'd0});

    // x0 hard-wired
    core_cyc(0, 2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, {4'd0, 4'd0, 4'd0, 4'd0});
    idle_cyc();
    dbg_go(1, 0, 32'hFFFFFFFF, rc);
    idle_cyc();
    dbg_go(0, 0, 0, rc);
    core_cyc(0, 2'b00, 0, 0, 0, 0, {4'd0, 4'd0, 4'd0, 4'd0});

    // debug read with an idle core: ack one cycle after request
    core_cyc(0, 2'b01, 7, 32'h55, 0, 0, {4'd7, 4'd6, 4'd5, 4'd0});
    idle_cyc();
    dbg_go(0, 7, 0, rc);
    check("dbg_read_latency", ack_cyc - rc, 32'd1);
    check("no_stall_idle", stall_cyc, 32'hFFFFFFFF);

    // debug write against a continuously writing core
    fork
      begin
        for (int k = 0; k < 32; k++) begin
          if (stall_last) begin
            core_cyc(0, 2'b00, 0, 0, 0, 0, rand_ra(1));
          end else begin
            a0c = $urandom_range(1, NREGS - 1);
            if (a0c == 9) a0c = 10;
            core_cyc(0, 2'($urandom_range(1, 3)), AW'(a0c), $urandom,
                     AW'(a0c == 1 ? 2 : a0c - 1), $urandom, rand_ra(1));
          end
        end
        idle_cyc();
      end
      begin
        repeat (2) @(posedge clk);
        dbg_go(1, 9, 32'h77, rc);
        check("stall_after_wait", stall_cyc - rc, 32'd17);
      end
    join
    for (int i = 0; i < NREGS; i += NRD)
      core_cyc(0, 2'b00, 0, 0, 0, 0,
               {AW'(i + 3), AW'(i + 2), AW'(i + 1), AW'(i)});

    // request withdrawn before ack: no access, no ack
    rc = ack_cnt;
    core_cyc(0, 2'b01, 2, 32'h22, 0, 0, rand_ra(0));
    bus.dbg_req_i = 1; bus.dbg_we_i = 1; bus.dbg_add_i = 11; bus.dbg_wdata_i = 32'hDEAD;
    core_cyc(0, 2'b01, 2, 32'h23, 0, 0, rand_ra(0));
    core_cyc(0, 2'b10, 0, 0, 4, 32'h44, rand_ra(0));
    bus.dbg_req_i = 0;
    repeat (3) idle_cyc();
    core_cyc(0, 2'b00, 0, 0, 0, 0, {4'd11, 4'd11, 4'd4, 4'd2});
    check("withdrawn_no_ack", ack_cnt - rc, 32'd0);
    check("withdrawn_no_stall", {31'b0, bus.stall_o}, 32'd0);

    // reset during WAIT aborts the pending access
    core_cyc(0, 2'b01, 3, 32'h99, 0, 0, rand_ra(0));
    bus.dbg_req_i = 1; bus.dbg_we_i = 0; bus.dbg_add_i = 3;
    rc = ack_cnt;
    for (int k = 0; k < 4; k++) core_cyc(0, 2'b01, 5, $urandom, 0, 0, rand_ra(0));
    core_cyc(1, 2'b01, 6, 32'h66, 0, 0, {4'd3, 4'd3, 4'd6, 4'd5});
    bus.dbg_req_i = 0;
    core_cyc(0, 2'b00, 0, 0, 0, 0, {4'd3, 4'd6, 4'd5, 4'd9});
    idle_cyc();
    check("rst_abort_no_ack", ack_cnt - rc, 32'd0);
    check("rst_abort_stall", {31'b0, bus.stall_o}, 32'd0);
    dbg_go(0, 3, 0, rc);
    check("post_rst_latency", ack_cyc - rc, 32'd1);

    // randomized core traffic on all four read ports
    for (int k = 0; k < 300; k++)
      core_cyc(0, 2'($urandom_range(0, 3)), AW'($urandom), $urandom,
               AW'($urandom), $urandom, rand_ra(0));
    idle_cyc();
    for (int i = 0; i < NREGS; i += NRD)
      core_cyc(0, 2'b00, 0, 0, 0, 0,
               {AW'(i + 3), AW'(i + 2), AW'(i + 1), AW'(i)});
    dbg_go(0, 13, 0, rc);
    idle_cyc();
    repeat (2) @(negedge clk);
    check("dbg_q_drained", dbg_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter XLEN, default 32, register data width.
REQ-002 SHALL provide parameter NREGS, default 32, register count (power of two, 2..64); AW = log2(NREGS).
REQ-003 SHALL provide parameter NRD, default 2, core read port count (1..4).
REQ-004 SHALL provide parameter DBG_TIMEOUT, default 15, cycles a debug request waits before stalling the core.
REQ-005 SHALL provide port: clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL provide port: rst  input  1  synchronous, active-high reset.
REQ-007 SHALL provide port: wr_en_i  input  2  per-core-write-port enable (port 0, port 1).
REQ-008 SHALL provide port: wr_add_i  input  2*AW  write addresses; port p at bits [p*AW +: AW].
REQ-009 SHALL provide port: wr_data_i  input  2*XLEN  write data, packed the same way.
REQ-010 SHALL provide port: r_add_i  input  NRD*AW  packed read addresses.
REQ-011 SHALL provide port: r_data_o  output  NRD*XLEN  packed read data, combinational.
REQ-012 SHALL provide port: dbg_req_i  input  1  debug access request, held until dbg_ack_o.
REQ-013 SHALL provide port: dbg_we_i  input  1  debug access is a write (1) or a read (0).
REQ-014 SHALL provide port: dbg_add_i  input  AW  debug register address.
REQ-015 SHALL provide port: dbg_wdata_i  input  XLEN  debug write data.
REQ-016 SHALL provide port: dbg_rdata_o  output  XLEN  debug read data, valid while dbg_ack_o=1.
REQ-017 SHALL provide port: dbg_ack_o  output  1  one-cycle completion pulse.
REQ-018 SHALL provide port: stall_o  output  1  core must hold writes (wr_en_i=0) next cycle.

Function
REQ-019 SHALL hard-wire register 0 to zero: writes to address 0 from any source are ignored; reads of address 0 return 0.
REQ-020 SHALL commit each enabled core write at the rising edge; if both ports target the same nonzero address, port 1 data SHALL win.
REQ-021 SHALL bypass each read port: if r_add equals an enabled write address (nonzero), return that write data (port 1 over port 0); otherwise return array contents.
REQ-022 SHALL run debug FSM states IDLE, WAIT, STALL, ACCESS with registered dbg_ack_o and dbg_rdata_o.
REQ-023 IDLE: on dbg_req_i=1, go to ACCESS if wr_en_i==0 this cycle, else go to WAIT with wait counter cleared.
REQ-024 WAIT: go to ACCESS on first cycle with wr_en_i==0; otherwise increment counter; when counter reaches DBG_TIMEOUT go to STALL.
REQ-025 STALL: assert stall_o=1; go to ACCESS on first cycle with wr_en_i==0 (core write issued in the stall_o cycle still commits).
REQ-026 ACCESS: perform debug write (REQ-019 applies) or capture read of the array; pulse dbg_ack_o=1 for exactly that cycle's registered output; return to IDLE.
REQ-027 A debug read SHALL return the array value after all earlier-committed writes (no bypass needed, since the port is idle).
REQ-028 dbg_req_i deasserting before ack SHALL return FSM to IDLE with no access and no ack.
REQ-029 After dbg_ack_o the FSM SHALL spend at least one cycle in IDLE before accepting a new request.
REQ-030 Core writes SHALL never be dropped; debug writes SHALL occur only in cycles with no core write.

Reset
REQ-031 On rst=1 at a clock edge: all registers SHALL clear to 0, FSM to IDLE, counter to 0, dbg_ack_o=0, dbg_rdata_o=0, stall_o=0.
REQ-032 While rst=1, r_data_o SHALL read 0 for all ports and writes SHALL be ignored; reset mid-debug-access SHALL abort with no ack.

Verification
REQ-033 Write port 0 x5=0x1234 and port 1 x5=0xABCD same cycle, read port 0 at x5 same cycle -> r_data 0xABCD; next cycle array x5=0xABCD.
REQ-034 Write x0=0xFFFFFFFF on both ports and via debug -> all reads of x0 return 0, dbg read of x0 returns 0.
REQ-035 dbg_req read x7 (x7=0x55) with wr_en_i=0 -> dbg_ack_o=1 and dbg_rdata_o=0x55 one cycle after request; stall_o stays 0.
REQ-036 Core writes every cycle, DBG_TIMEOUT=15, debug write x9=0x77 -> stall_o asserts after 16 WAIT cycles; first idle write cycle commits x9=0x77 and ack pulses; no core write lost.
REQ-037 Assert rst for one cycle during WAIT with x3=0x99 -> x3 reads 0, FSM in IDLE, no dbg_ack_o, stall_o=0.
REQ-038 NRD=4, NREGS=16 build: all four read ports return independent correct values for random address/write sequences against a reference model.
